fifo_sync_n2w: RTL and testbench

//  Synchronous narrow-in / wide-out FIFO, the packing counterpart of the wide-to-narrow FIFO.

---
 rtl/fifo_sync_n2w_pkg.sv | 30 +++
 rtl/fifo_n2w_packer.sv | 52 +++++
 rtl/fifo_sync_n2w.sv | 95 +++++++++
 tb/tb_fifo_sync_n2w.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sync_n2w_pkg.sv
// Shared helpers for the narrow-to-wide FIFO: lane ratio/width derivation and lane ordering.
// Optional flush support in fifo_sync_n2w is enabled with FIFO_N2W_FLUSH_EN.
package fifo_sync_n2w_pkg;

   // Narrow beat k occupies the k-th lane counted from the LSB.
   localparam bit LANE_ORDER_LE = 1'b1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   function automatic int lane_ratio(input int out_w, input int in_w);
      return out_w / in_w;
   endfunction

   function automatic int lane_lsb(input int lane, input int in_w, input int ratio);
      if (LANE_ORDER_LE) begin
         return lane * in_w;
      end
      return (ratio - 1 - lane) * in_w;
   endfunction

endpackage

// File: rtl/fifo_n2w_packer.sv
// Lane counter and packing register: collects narrow beats and pulses commit with the
// assembled wide word on the edge that completes (or flushes) it.
module fifo_n2w_packer
   import fifo_sync_n2w_pkg::*;
#(
   parameter int IN_W  = 8,
   parameter int OUT_W = 32,
   localparam int RATIO  = lane_ratio(OUT_W, IN_W),
   localparam int LANE_W = clog2(RATIO)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              beat,
   input  logic [IN_W-1:0]   data,
   input  logic              flush,
   output logic              commit,
   output logic [OUT_W-1:0]  word,
   output logic [LANE_W-1:0] lane_num
);

   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(RATIO - 1);

   logic [OUT_W-1:0] packer;

   // Word as it would look after this cycle's beat; unfilled lanes are still zero.
   always_comb begin
      word = packer;
      if (beat) begin
         word[lane_lsb(int'(lane_num), IN_W, RATIO) +: IN_W] = data;
      end
   end

   // A flush with nothing packed and no beat this cycle has nothing to commit.
   always_comb begin
      commit = (beat && (lane_num == LANE_LAST)) ||
               (flush && ((lane_num != '0) || beat));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         packer   <= '0;
         lane_num <= '0;
      end else if (commit) begin
         packer   <= '0;
         lane_num <= '0;
      end else if (beat) begin
         packer   <= word;
         lane_num <= lane_num + 1'b1;
      end
   end

endmodule

// File: rtl/fifo_sync_n2w.sv
// Synchronous narrow-in / wide-out FIFO with show-ahead read port.
// Defining FIFO_N2W_FLUSH_EN adds a flush input that commits a partially packed word.
module fifo_sync_n2w
   import fifo_sync_n2w_pkg::*;
#(
   parameter int ADDR_WIDTH     = 2,
   parameter int DATA_IN_WIDTH  = 8,
   parameter int DATA_OUT_WIDTH = 32,
   localparam int RATIO  = lane_ratio(DATA_OUT_WIDTH, DATA_IN_WIDTH),
   localparam int LANE_W = clog2(RATIO),
   localparam int DEPTH  = 2 ** ADDR_WIDTH
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      wr_req,
   input  logic [DATA_IN_WIDTH-1:0]  data,
   output logic                      wr_full,
   input  logic                      rd_req,
   output logic [DATA_OUT_WIDTH-1:0] q,
   output logic                      rd_empty,
   output logic [ADDR_WIDTH:0]       fifo_num,
   output logic [LANE_W-1:0]         lane_num
`ifdef FIFO_N2W_FLUSH_EN
   ,
   input  logic                      flush
`endif
);

   logic [DATA_OUT_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0]     wr_addr;
   logic [ADDR_WIDTH-1:0]     rd_addr;
   logic                      wr_accept;
   logic                      rd_accept;
   logic                      flush_go;
   logic                      commit;
   logic [DATA_OUT_WIDTH-1:0] word;

   assign rd_empty  = (fifo_num == '0);
   assign wr_full   = (fifo_num == (ADDR_WIDTH + 1)'(DEPTH));
   assign wr_accept = wr_req && !wr_full;
   assign rd_accept = rd_req && !rd_empty;
   assign q         = mem[rd_addr];

   // Flush is held off while full so a commit can never overrun storage.
`ifdef FIFO_N2W_FLUSH_EN
   assign flush_go = flush && !wr_full;
`else
   assign flush_go = 1'b0;
`endif

   fifo_n2w_packer #(
      .IN_W  (DATA_IN_WIDTH),
      .OUT_W (DATA_OUT_WIDTH)
   ) u_packer (
      .clk      (clk),
      .rstn     (rstn),
      .beat     (wr_accept),
      .data     (data),
      .flush    (flush_go),
      .commit   (commit),
      .word     (word),
      .lane_num (lane_num)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (commit) begin
         mem[wr_addr] <= word;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_addr  <= '0;
         rd_addr  <= '0;
         fifo_num <= '0;
      end else begin
         if (commit) begin
            wr_addr <= wr_addr + 1'b1;
         end
         if (rd_accept) begin
            rd_addr <= rd_addr + 1'b1;
         end
         case ({commit, rd_accept})
            2'b10:   fifo_num <= fifo_num + 1'b1;
            2'b01:   fifo_num <= fifo_num - 1'b1;
            default: fifo_num <= fifo_num;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_sync_n2w.sv
// Bench for fifo_sync_n2w: directed steps then randomized traffic against a queue model.
// Flush steps are compiled in only when FIFO_N2W_FLUSH_EN is defined.
module tb_fifo_sync_n2w;

   localparam int AW    = 2;
   localparam int IW    = 8;
   localparam int OW    = 32;
   localparam int RATIO = OW / IW;
   localparam int DEPTH = 2 ** AW;

   logic          clk;
   logic          rstn;
   logic          wr_req;
   logic [IW-1:0] data;
   logic          wr_full;
   logic          rd_req;
   logic [OW-1:0] q;
   logic          rd_empty;
   logic [AW:0]   fifo_num;
   logic [1:0]    lane_num;
   logic          flush;

   int checks;
   int errors;

   // Model: complete words in order, plus the narrow beats not yet packed.
   logic [OW-1:0] exp_q[$];
   logic [IW-1:0] part_q[$];

   fifo_sync_n2w #(
      .ADDR_WIDTH     (AW),
      .DATA_IN_WIDTH  (IW),
      .DATA_OUT_WIDTH (OW)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .wr_req   (wr_req),
      .data     (data),
      .wr_full  (wr_full),
      .rd_req   (rd_req),
      .q        (q),
      .rd_empty (rd_empty),
      .fifo_num (fifo_num),
      .lane_num (lane_num)
`ifdef FIFO_N2W_FLUSH_EN
      ,
      .flush    (flush)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".fifo_num"}, OW'(fifo_num), OW'(exp_q.size()));
      chk({tag, ".lane_num"}, OW'(lane_num), OW'(part_q.size()));
      chk({tag, ".rd_empty"}, OW'(rd_empty), OW'(exp_q.size() == 0));
      chk({tag, ".wr_full"},  OW'(wr_full),  OW'(exp_q.size() == DEPTH));
      if (exp_q.size() != 0) begin
         chk({tag, ".q"}, q, exp_q[0]);
      end
   endtask

   task automatic commit_part();
      logic [OW-1:0] w;
      w = '0;
      for (int i = 0; i < part_q.size(); i++) begin
         w[i*IW +: IW] = part_q[i];
      end
      exp_q.push_back(w);
      part_q.delete();
   endtask

   // One clock edge of the FIFO contract, evaluated on the state before the edge.
   task automatic model_edge(input logic wr, input logic [IW-1:0] d, input logic rd,
                             input logic fl);
      bit full;
      bit empty;
      bit fl_on;
      full  = (exp_q.size() == DEPTH);
      empty = (exp_q.size() == 0);
`ifdef FIFO_N2W_FLUSH_EN
      fl_on = fl;
`else
      fl_on = 1'b0 & fl;
`endif
      if (rd && !empty) void'(exp_q.pop_front());
      if (wr && !full) part_q.push_back(d);
      if (part_q.size() == RATIO) commit_part();
      else if (fl_on && !full && part_q.size() != 0) commit_part();
   endtask

   task automatic step(input logic wr, input logic [IW-1:0] d, input logic rd,
                       input logic fl);
      wr_req = wr;
      data   = d;
      rd_req = rd;
      flush  = fl;
      #1;
      check_state("pre");
      model_edge(wr, d, rd, fl);
      @(posedge clk);
      #1;
      wr_req = 1'b0;
      rd_req = 1'b0;
      flush  = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rstn   = 1'b0;
      wr_req = 1'b0;
      rd_req = 1'b0;
      flush  = 1'b0;
      data   = '0;
      @(posedge clk);
      #1;
      chk("reset.q", q, '0);
      check_state("reset");
      rstn = 1'b1;

      // Four bytes pack little-endian into one word.
      step(1, 8'h11, 0, 0);
      step(1, 8'h22, 0, 0);
      step(1, 8'h33, 0, 0);
      step(1, 8'h44, 0, 0);
      chk("t1.q", q, 32'h4433_2211);
      chk("t1.fifo_num", OW'(fifo_num), 32'd1);
      chk("t1.rd_empty", OW'(rd_empty), 32'd0);
      step(0, 8'h00, 1, 0);
      chk("t1.drain_empty", OW'(rd_empty), 32'd1);

      // Fill to full; the 17th byte must be ignored.
      for (int i = 0; i < 16; i++) step(1, IW'(i + 1), 0, 0);
      chk("t2.wr_full", OW'(wr_full), 32'd1);
      chk("t2.fifo_num", OW'(fifo_num), 32'd4);
      step(1, 8'hEE, 0, 0);
      chk("t2.lane_num", OW'(lane_num), 32'd0);
      chk("t2.fifo_num_after", OW'(fifo_num), 32'd4);
      for (int j = 0; j < 4; j++) begin
         chk("t2.read_q", q, {8'(4*j+4), 8'(4*j+3), 8'(4*j+2), 8'(4*j+1)});
         step(0, 8'h00, 1, 0);
      end
      chk("t2.rd_empty", OW'(rd_empty), 32'd1);

      // Commit and pop in the same cycle across three pointer laps.
      for (int i = 0; i < 8; i++) step(1, IW'($urandom), 0, 0);
      for (int lap = 0; lap < 3 * DEPTH; lap++) begin
         for (int i = 0; i < RATIO - 1; i++) step(1, IW'($urandom), 0, 0);
         chk("t3.lane_num", OW'(lane_num), 32'd3);
         step(1, IW'($urandom), 1, 0);
         chk("t3.fifo_num", OW'(fifo_num), 32'd2);
      end
      step(0, 8'h00, 1, 0);
      step(0, 8'h00, 1, 0);
      chk("t3.rd_empty", OW'(rd_empty), 32'd1);

      // Asynchronous reset mid-packing.
      step(1, 8'hAA, 0, 0);
      step(1, 8'hBB, 0, 0);
      rstn = 1'b0;
      #1;
      exp_q.delete();
      part_q.delete();
      chk("t4.lane_num", OW'(lane_num), 32'd0);
      chk("t4.fifo_num", OW'(fifo_num), 32'd0);
      chk("t4.q", q, 32'd0);
      chk("t4.rd_empty", OW'(rd_empty), 32'd1);
      @(posedge clk);
      #1;
      rstn = 1'b1;

`ifdef FIFO_N2W_FLUSH_EN
      step(1, 8'h01, 0, 0);
      step(1, 8'h02, 0, 0);
      step(1, 8'h03, 0, 1);
      chk("t5.q", q, 32'h0003_0201);
      chk("t5.lane_num", OW'(lane_num), 32'd0);
      step(0, 8'h00, 0, 1);
      chk("t5.idle_flush_num", OW'(fifo_num), 32'd1);
      step(0, 8'h00, 1, 0);
`endif

      // Randomized traffic: fill-biased then drain-biased.
      for (int c = 0; c < 1000; c++) begin
         logic wr;
         logic rd;
         logic fl;
         wr = ($urandom_range(0, 3) != 0);
         rd = (c < 500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
         fl = ($urandom_range(0, 15) == 0);
         step(wr, IW'($urandom), rd, fl);
      end
      check_state("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
